rst_seq: RTL and testbench
==========================

# rst_seq

Parametrised reset sequencer that generalises the two-flop asynchronous-assert / synchronous-release reset synchroniser. It takes one asynchronous reset `irst` and produces `NCH` reset outputs in the `clk` domain. Each output asserts immediately and asynchronously, and releases synchronously after a configurable synchroniser depth and a minimum stretch time. Channels then release one at a time in fixed order, so downstream sub-domains come out of reset in a defined sequence, for example PLL-dependent logic before datapath before host interface.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count; legal values 2..8.
- `NCH`, default 4: number of reset outputs; legal values 1..16.
- `STRETCH`, default 16: cycles of extra hold after the synchroniser releases; 0 is legal.
- `STAGGER`, default 8: cycles between successive channel releases; 0 releases all channels on the same edge.
- `clk`  in  1  sequencer clock.
- `irst`  in  1  reset, asynchronous, active-high.
- `orst`  out  NCH  per-channel reset, active-high; bit 0 releases first.
- `odone`  out  1  high once every channel is released.
- `swrst_req`  in  1  software reset request, level, synchronous to `clk`. Present only with `RST_SEQ_SWRST_EN`.
- `swrst_ack`  out  1  one-cycle acceptance pulse. Present only with `RST_SEQ_SWRST_EN`.

## Operation
- All state and output flops have an asynchronous preset or clear on `irst`. Power-up initial values equal the reset values.
- Reset values: `orst` = all ones, `odone` = 0, `swrst_ack` = 0, synchroniser chain = all ones, state = SYNC, counter = 0.
- Synchroniser chain: `SYNC_STAGES` flops marked ASYNC_REG. Input is constant 0; each flop shifts toward the output. The chain output is the synchronised reset.
- State machine:
  - SYNC: wait while the chain output is 1. When it reads 0, load counter = `STRETCH` and go to STRETCH.
  - STRETCH: decrement the counter each cycle. At counter = 0, clear `orst[0]`, load counter = `STAGGER`, set channel index = 1, and go to RELEASE. If `NCH` = 1, set `odone` and go to DONE instead.
  - RELEASE: decrement the counter each cycle. At counter = 0, clear `orst[index]` and reload `STAGGER`. When the index reaches `NCH-1`, also set `odone` and go to DONE.
  - DONE: hold all outputs.
- `STAGGER` = 0: all channels clear on the STRETCH-exit edge. RELEASE is skipped.
- `STRETCH` = 0: STRETCH exits on its first edge.
- Counter width is clog2(max(`STRETCH`, `STAGGER`) + 1), with a minimum of 1. Index width is clog2(`NCH`), with a minimum of 1.
- Reset mid-operation: `irst` high in any state immediately forces all outputs and state back to their reset values, with no clock required. The full sequence restarts after release.
- Glitch on `irst` shorter than one cycle: still fully resets the block. There is no filtering.
- Outputs are monotonic within one sequence. Once `orst[k]` clears, it stays low until the next reset, either `irst` or software.

## Timing
- Edge 1 is the first rising `clk` edge with `irst` low and recovery met.
- The chain output goes low after edge `SYNC_STAGES`. STRETCH is entered on that edge.
- `orst[k]` clears after edge `SYNC_STAGES` + `STRETCH` + 1 + k·`STAGGER`. `odone` rises on the same edge as `orst[NCH-1]` clears.
- Assertion latency from `irst` rising to `orst` high is combinational through the async preset only. There is no clocked delay.
- All outputs come straight from flops, with no combinational decode.

## Configuration
- `RST_SEQ_SWRST_EN` defined: `swrst_req`/`swrst_ack` ports and logic exist.
  - In DONE, `swrst_req` = 1 on an edge sets `orst` to all ones, clears `odone`, pulses `swrst_ack` for one cycle, loads counter = `STRETCH`, and goes to STRETCH. The synchroniser is bypassed.
  - The requester holds `swrst_req` until it sees `swrst_ack`.
  - A request outside DONE is held off, with no ack, until DONE is reached.
  - `irst` takes priority over any software request.
- `RST_SEQ_SWRST_EN` undefined: the ports are absent and DONE is terminal until `irst`.

## Structure
- Shared package `rst_seq_pkg` holds:
  - the state enum (SYNC, STRETCH, RELEASE, DONE);
  - the clog2-based width helper function;
  - the legal-range constants for `SYNC_STAGES` and `NCH`.
- One sub-module, `rst_sync_chain`, is parameterised by depth, uses async preset and ASYNC_REG, and is reusable standalone.
- Sequencer FSM, counter and output registers live in `rst_seq`. Target size is about 150–250 lines.

## Test plan
- Defaults, `irst` pulse of 5 cycles then low → `orst[0..3]` clear after edges 19, 27, 35, 43; `odone` rises after edge 43.
- `STAGGER` = 0, `STRETCH` = 0, `SYNC_STAGES` = 3 → all four channels clear together after edge 4; `odone` rises on the same edge.
- `irst` re-asserted 3 cycles after `orst[1]` clears → all `orst` go to 1 with no clock edge and `odone` = 0; the sequence restarts and completes with the same edge counts relative to the new release.
- `irst` glitch of 0.3 cycle during DONE → full reset; re-sequence matches the default timing.
- `RST_SEQ_SWRST_EN` defined, `swrst_req` raised in DONE → `swrst_ack` high for exactly 1 cycle; `orst` all ones on the next edge; `orst[0]` clears after `STRETCH` + 1 edges.
- `RST_SEQ_SWRST_EN` defined, `swrst_req` raised mid-RELEASE → no ack until DONE; then acked and re-sequenced.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the reset sequencer.
//   - rst_state_t : sequencer state encoding
//   - min1_clog2  : clog2 helper that never returns less than 1
//   - legal parameter ranges for the synchroniser depth and channel count
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } rst_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 8;
  localparam int NCH_MIN         = 1;
  localparam int NCH_MAX         = 16;

  // Register width for a value of v states; a zero-width vector is never
  // useful, so the result is clamped to 1.
  function automatic int min1_clog2(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: asynchronous-assert / synchronous-release reset synchroniser.
// Usable on its own wherever a single synchronised reset is needed.
//   DEPTH  number of synchroniser flops (>= 2)
//   clk    destination clock
//   irst   asynchronous active-high reset; presets every flop
//   orst   synchronised active-high reset (last flop of the chain)
module rst_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic irst,
  output logic orst
);

  (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] chain;

  // A constant 0 is shifted in at bit 0 and travels toward bit DEPTH-1, so
  // release reaches the output DEPTH edges after irst drops.
  always_ff @(posedge clk or posedge irst) begin
    if (irst) chain <= '1;
    else      chain <= {chain[DEPTH-2:0], 1'b0};
  end

  assign orst = chain[DEPTH-1];

endmodule

// File: rtl/rst_seq.sv
// rst_seq: staggered reset sequencer.
// One asynchronous reset produces NCH resets in the clk domain. Every output
// asserts asynchronously with irst; release is synchronous, held for STRETCH
// cycles after synchronisation, then channels drop one at a time, STAGGER
// cycles apart, lowest index first.
//   clk        sequencer clock
//   irst       asynchronous active-high reset
//   orst       per-channel active-high resets, bit 0 releases first
//   odone      high once every channel is released
//   swrst_req  software reset request (only with RST_SEQ_SWRST_EN)
//   swrst_ack  one-cycle acceptance pulse (only with RST_SEQ_SWRST_EN)
// Optional feature macro: RST_SEQ_SWRST_EN adds the software-reset handshake;
// without it DONE is terminal until irst.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NCH         = 4,
  parameter int STRETCH     = 16,
  parameter int STAGGER     = 8
) (
  input  logic           clk,
  input  logic           irst,
  output logic [NCH-1:0] orst,
  output logic           odone
`ifdef RST_SEQ_SWRST_EN
  ,
  input  logic           swrst_req,
  output logic           swrst_ack
`endif
);

  // Out-of-range depths are clamped into the supported range.
  localparam int DEPTH = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                         (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                         SYNC_STAGES;
  localparam int MAXCNT = (STRETCH > STAGGER) ? STRETCH : STAGGER;
  localparam int CW     = min1_clog2(MAXCNT + 1);
  localparam int IW     = min1_clog2(NCH);

  localparam logic [CW-1:0] STRETCH_M1 = CW'((STRETCH > 0) ? STRETCH - 1 : 0);
  localparam logic [CW-1:0] STAGGER_M1 = CW'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NCH - 1);
`ifdef RST_SEQ_SWRST_EN
  localparam logic [CW-1:0] STRETCH_C  = CW'(STRETCH);
`endif

  logic           sync_rst;
  rst_state_t     state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [NCH-1:0] orst_nxt;
  logic           done_nxt;
  logic           first_go;
`ifdef RST_SEQ_SWRST_EN
  logic           ack_nxt;
`endif

  rst_sync_chain #(.DEPTH(DEPTH)) u_sync (
    .clk  (clk),
    .irst (irst),
    .orst (sync_rst)
  );

  always_ff @(posedge clk or posedge irst) begin
    if (irst) begin
      state <= ST_SYNC;
      cnt   <= '0;
      idx   <= '0;
      orst  <= '1;
      odone <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      orst  <= orst_nxt;
      odone <= done_nxt;
    end
  end

`ifdef RST_SEQ_SWRST_EN
  always_ff @(posedge clk or posedge irst) begin
    if (irst) swrst_ack <= 1'b0;
    else      swrst_ack <= ack_nxt;
  end
`endif

  // The FSM only acts once the synchroniser output itself is low, so the full
  // chain depth protects the release. That costs one edge, so the stretch
  // count starts one lower to keep the release at edge
  // SYNC_STAGES + STRETCH + 1; with STRETCH = 0 the release happens directly.
  // Counters are loaded with N-1 and act at 0, giving N edges per interval.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    orst_nxt  = orst;
    done_nxt  = odone;
    first_go  = 1'b0;
`ifdef RST_SEQ_SWRST_EN
    ack_nxt   = 1'b0;
`endif
    case (state)
      ST_SYNC: begin
        if (!sync_rst) begin
          if (STRETCH == 0) begin
            first_go = 1'b1;
          end else begin
            state_nxt = ST_STRETCH;
            cnt_nxt   = STRETCH_M1;
          end
        end
      end
      ST_STRETCH: begin
        if (cnt == '0) first_go = 1'b1;
        else           cnt_nxt  = cnt - CW'(1);
      end
      ST_RELEASE: begin
        if (cnt == '0) begin
          orst_nxt[idx] = 1'b0;
          if (idx == LAST_IDX) begin
            done_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            idx_nxt = idx + IW'(1);
            cnt_nxt = STAGGER_M1;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_DONE: begin
`ifdef RST_SEQ_SWRST_EN
        // Software reset skips the synchroniser: the request is already
        // synchronous to clk.
        if (swrst_req) begin
          orst_nxt  = '1;
          done_nxt  = 1'b0;
          ack_nxt   = 1'b1;
          cnt_nxt   = STRETCH_C;
          state_nxt = ST_STRETCH;
        end
`endif
      end
      default: state_nxt = ST_SYNC;
    endcase

    // Release of channel 0; with a single channel or no stagger this also
    // finishes the whole sequence on the same edge.
    if (first_go) begin
      orst_nxt[0] = 1'b0;
      if (NCH == 1 || STAGGER == 0) begin
        orst_nxt  = '0;
        done_nxt  = 1'b1;
        state_nxt = ST_DONE;
      end else begin
        cnt_nxt   = STAGGER_M1;
        idx_nxt   = IW'(1);
        state_nxt = ST_RELEASE;
      end
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed self-checking bench for rst_seq.
// Instance a uses the default parameters; instance b uses SYNC_STAGES=3,
// STRETCH=0, STAGGER=0. Both share clk and irst. Define RST_SEQ_SWRST_EN to
// also exercise the software-reset handshake on instance a.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       irst = 1'b1;
  logic [3:0] orst_a, orst_b;
  logic       odone_a, odone_b;
`ifdef RST_SEQ_SWRST_EN
  logic       swrst_req = 1'b0;
  logic       swrst_ack;
  logic       swrst_req_b = 1'b0;
  logic       swrst_ack_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int rerise   = 0;
  int clr_a[4];
  int clr_b[4];
  int done_a, done_b;

  always #5 clk = ~clk;

  rst_seq dut_a (
    .clk   (clk),
    .irst  (irst),
    .orst  (orst_a),
    .odone (odone_a)
`ifdef RST_SEQ_SWRST_EN
    ,
    .swrst_req (swrst_req),
    .swrst_ack (swrst_ack)
`endif
  );

  rst_seq #(.SYNC_STAGES(3), .NCH(4), .STRETCH(0), .STAGGER(0)) dut_b (
    .clk   (clk),
    .irst  (irst),
    .orst  (orst_b),
    .odone (odone_b)
`ifdef RST_SEQ_SWRST_EN
    ,
    .swrst_req (swrst_req_b),
    .swrst_ack (swrst_ack_b)
`endif
  );

  // Records, for edges first..last, the first edge each channel is seen low
  // and the first edge odone is seen high; counts any channel re-asserting.
  task automatic watch(input int first, input int last);
    for (int k = 0; k < 4; k++) begin
      clr_a[k] = -1;
      clr_b[k] = -1;
    end
    done_a = -1;
    done_b = -1;
    for (int e = first; e <= last; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (orst_a[k] === 1'b1 && clr_a[k] >= 0) rerise++;
        if (orst_b[k] === 1'b1 && clr_b[k] >= 0) rerise++;
        if (orst_a[k] === 1'b0 && clr_a[k] < 0) clr_a[k] = e;
        if (orst_b[k] === 1'b0 && clr_b[k] < 0) clr_b[k] = e;
      end
      if (odone_a === 1'b1 && done_a < 0) done_a = e;
      if (odone_b === 1'b1 && done_b < 0) done_b = e;
    end
  endtask

  task automatic release_irst();
    @(negedge clk);
    irst = 1'b0;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (orst_a !== 4'hF || odone_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_a: got orst=%h odone=%b expected orst=f odone=0", orst_a, odone_a);
    end
    n_checks++;
    if (orst_b !== 4'hF || odone_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_b: got orst=%h odone=%b expected orst=f odone=0", orst_b, odone_b);
    end
  endtask

  task automatic test_default_sequence();
    int exp_a[4];
    exp_a = '{19, 27, 35, 43};
    @(negedge clk);
    irst = 1'b1;
    repeat (5) @(posedge clk);
    release_irst();
    rerise = 0;
    watch(1, 60);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (clr_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("[TB] FAIL default_a_ch%0d: cleared at edge %0d expected %0d", k, clr_a[k], exp_a[k]);
      end
      n_checks++;
      if (clr_b[k] !== 4) begin
        n_fail++;
        $display("[TB] FAIL default_b_ch%0d: cleared at edge %0d expected 4", k, clr_b[k]);
      end
    end
    n_checks++;
    if (done_a !== 43) begin
      n_fail++;
      $display("[TB] FAIL default_a_done: rose at edge %0d expected 43", done_a);
    end
    n_checks++;
    if (done_b !== 4) begin
      n_fail++;
      $display("[TB] FAIL default_b_done: rose at edge %0d expected 4", done_b);
    end
    n_checks++;
    if (rerise !== 0) begin
      n_fail++;
      $display("[TB] FAIL monotonic: %0d re-assertions seen expected 0", rerise);
    end
  endtask

  task automatic test_mid_reset();
    int exp_a[4];
    exp_a = '{19, 27, 35, 43};
    // Start from an existing completed sequence: reset, release, go to edge 30.
    @(negedge clk);
    irst = 1'b1;
    repeat (2) @(posedge clk);
    release_irst();
    watch(1, 30);
    n_checks++;
    if (orst_a !== 4'hC) begin
      n_fail++;
      $display("[TB] FAIL mid_pre_state: got orst=%h expected c", orst_a);
    end
    #2;
    irst = 1'b1;
    #1;
    n_checks++;
    if (orst_a !== 4'hF || odone_a !== 1'b0 || orst_b !== 4'hF || odone_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_async_assert: got a=%h/%b b=%h/%b expected f/0 f/0",
               orst_a, odone_a, orst_b, odone_b);
    end
    repeat (2) @(posedge clk);
    release_irst();
    watch(1, 60);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (clr_a[k] !== exp_a[k] || clr_b[k] !== 4) begin
        n_fail++;
        $display("[TB] FAIL mid_reseq_ch%0d: cleared a=%0d b=%0d expected a=%0d b=4",
                 k, clr_a[k], clr_b[k], exp_a[k]);
      end
    end
    n_checks++;
    if (done_a !== 43 || done_b !== 4) begin
      n_fail++;
      $display("[TB] FAIL mid_reseq_done: rose a=%0d b=%0d expected a=43 b=4", done_a, done_b);
    end
  endtask

  task automatic test_glitch();
    int exp_a[4];
    exp_a = '{19, 27, 35, 43};
    @(posedge clk);
    #2;
    irst = 1'b1;
    #3;
    irst = 1'b0;
    #1;
    n_checks++;
    if (orst_a !== 4'hF || odone_a !== 1'b0 || orst_b !== 4'hF || odone_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL glitch_assert: got a=%h/%b b=%h/%b expected f/0 f/0",
               orst_a, odone_a, orst_b, odone_b);
    end
    watch(1, 60);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (clr_a[k] !== exp_a[k] || clr_b[k] !== 4) begin
        n_fail++;
        $display("[TB] FAIL glitch_reseq_ch%0d: cleared a=%0d b=%0d expected a=%0d b=4",
                 k, clr_a[k], clr_b[k], exp_a[k]);
      end
    end
    n_checks++;
    if (done_a !== 43) begin
      n_fail++;
      $display("[TB] FAIL glitch_reseq_done: rose at edge %0d expected 43", done_a);
    end
  endtask

`ifdef RST_SEQ_SWRST_EN
  task automatic test_swrst_done();
    int exp_a[4];
    exp_a = '{17, 25, 33, 41};
    @(negedge clk);
    swrst_req = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (swrst_ack !== 1'b1 || orst_a !== 4'hF || odone_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL swrst_accept: got ack=%b orst=%h odone=%b expected 1 f 0",
               swrst_ack, orst_a, odone_a);
    end
    swrst_req = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (swrst_ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL swrst_ack_pulse: got ack=%b expected 0", swrst_ack);
    end
    watch(2, 60);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (clr_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("[TB] FAIL swrst_ch%0d: cleared at edge %0d expected %0d", k, clr_a[k], exp_a[k]);
      end
    end
    n_checks++;
    if (done_a !== 41) begin
      n_fail++;
      $display("[TB] FAIL swrst_done: rose at edge %0d expected 41", done_a);
    end
  endtask

  task automatic test_swrst_mid();
    int ack_edge;
    int exp_a[4];
    exp_a = '{61, 69, 77, 85};
    @(negedge clk);
    irst = 1'b1;
    repeat (2) @(posedge clk);
    release_irst();
    watch(1, 30);
    @(negedge clk);
    swrst_req = 1'b1;
    ack_edge = -1;
    for (int e = 31; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (swrst_ack === 1'b1 && ack_edge < 0) begin
        ack_edge = e;
        swrst_req = 1'b0;
      end
    end
    swrst_req = 1'b0;
    n_checks++;
    if (ack_edge !== 44) begin
      n_fail++;
      $display("[TB] FAIL swrst_mid_ack: acked at edge %0d expected 44", ack_edge);
    end
    watch(61, 100);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (clr_a[k] !== exp_a[k]) begin
        n_fail++;
        $display("[TB] FAIL swrst_mid_ch%0d: cleared at edge %0d expected %0d", k, clr_a[k], exp_a[k]);
      end
    end
    n_checks++;
    if (done_a !== 85) begin
      n_fail++;
      $display("[TB] FAIL swrst_mid_done: rose at edge %0d expected 85", done_a);
    end
  endtask
`endif

  initial begin
    $display("[TB] rst_seq directed test starting");
    test_reset();
    test_default_sequence();
    test_mid_reset();
    test_glitch();
`ifdef RST_SEQ_SWRST_EN
    test_swrst_done();
    test_swrst_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
